fifo_wr_cntrl: RTL

Write-side controller in front of the per-switch-instance FIFO bank; the FIFO read arbiter drains that bank.
- Accepts one serial packet stream (sop/eop framed, valid/ready handshake).
- Decodes the header beat to a destination FIFO and writes every accepted beat there, with its last flag.
- Drops packets with an unmapped address, and guarantees every written packet ends with a last-flagged entry (length limiter), so the reader never waits on an unterminated packet.

---
 rtl/sw_pkg.sv | 24 ++
 rtl/fifo_wr_cntrl_addr_decode.sv | 30 +++
 rtl/fifo_wr_cntrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// Constants and types shared by the FIFO write controller and the FIFO read arbiter.
package sw_pkg;

    localparam int unsigned NUM_SW_INST_DEF = 32'd5;
    localparam int unsigned W_WIDTH_DEF     = 32'd8;
    localparam int unsigned ADDR_BASE_DEF   = 32'h10;
    localparam int unsigned MAX_PKT_LEN_DEF = 32'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } fsm_t;

    // A single-FIFO build still needs a 1-bit destination index.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/fifo_wr_cntrl_addr_decode.sv
// Combinational header decode: maps a header beat to a destination FIFO index.
module addr_decode
    import sw_pkg::*;
#(
    parameter int unsigned NUM_SW_INST = NUM_SW_INST_DEF,
    parameter int unsigned W_WIDTH     = W_WIDTH_DEF,
    parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
    parameter int unsigned IDX_W       = idx_width(NUM_SW_INST)
) (
    input  logic [W_WIDTH-1:0] data_in,
    output logic               hit,
    output logic [IDX_W-1:0]   idx
);

    // One extra bit so ADDR_BASE+NUM_SW_INST cannot wrap at the top of the range.
    localparam logic [W_WIDTH:0] LO_ADDR = (W_WIDTH+1)'(ADDR_BASE);
    localparam logic [W_WIDTH:0] HI_ADDR = (W_WIDTH+1)'(ADDR_BASE + NUM_SW_INST);

    logic [W_WIDTH:0] w_ext;
    logic [W_WIDTH:0] w_off;

    // Range check and offset computation.
    always_comb begin
        w_ext = {1'b0, data_in};
        w_off = w_ext - LO_ADDR;
        hit   = (w_ext >= LO_ADDR) && (w_ext < HI_ADDR);
        idx   = IDX_W'(w_off);
    end

endmodule

// File: rtl/fifo_wr_cntrl.sv
// Write-side controller: steers each framed packet into its destination FIFO,
// dropping unmapped packets and forcing a terminating last entry on long ones.
module fifo_wr_cntrl
    import sw_pkg::*;
#(
    parameter int unsigned NUM_SW_INST = NUM_SW_INST_DEF,
    parameter int unsigned W_WIDTH     = W_WIDTH_DEF,
    parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
    parameter int unsigned MAX_PKT_LEN = MAX_PKT_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W_WIDTH-1:0]     data_in,
    input  logic                   valid_in,
    input  logic                   sop_in,
    input  logic                   eop_in,
    output logic                   ready_out,
    input  logic [NUM_SW_INST-1:0] full,
    output logic [NUM_SW_INST-1:0] wr_en,
    output logic [W_WIDTH-1:0]     wr_data,
    output logic                   wr_last,
    output logic                   pkt_drop,
    output logic                   pkt_trunc,
    output logic                   proto_err
);

    localparam int unsigned IDX_W = idx_width(NUM_SW_INST);
    localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN) + 32'd1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT_LEN - 32'd1);
    localparam logic [NUM_SW_INST-1:0] ONE_HOT0 = NUM_SW_INST'(1'b1);

    fsm_t             r_state;
    fsm_t             w_state_nxt;
    logic [IDX_W-1:0] r_dest;
    logic [IDX_W-1:0] w_dest_nxt;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_drop;
    logic             r_trunc;
    logic             r_perr;
    logic             w_drop_nxt;
    logic             w_trunc_nxt;
    logic             w_perr_nxt;
    logic             w_hit;
    logic [IDX_W-1:0] w_idx;

    addr_decode #(
        .NUM_SW_INST (NUM_SW_INST),
        .W_WIDTH     (W_WIDTH),
        .ADDR_BASE   (ADDR_BASE),
        .IDX_W       (IDX_W)
    ) u_addr_decode (
        .data_in (data_in),
        .hit     (w_hit),
        .idx     (w_idx)
    );

    assign wr_data   = data_in;
    assign pkt_drop  = r_drop;
    assign pkt_trunc = r_trunc;
    assign proto_err = r_perr;

    // Next-state, handshake and same-cycle write strobe generation.
    always_comb begin
        w_state_nxt = r_state;
        w_dest_nxt  = r_dest;
        w_cnt_nxt   = r_beat_cnt;
        w_drop_nxt  = 1'b0;
        w_trunc_nxt = 1'b0;
        w_perr_nxt  = 1'b0;
        ready_out   = 1'b0;
        wr_en       = '0;
        wr_last     = 1'b0;
        if (!rst_n) begin
            ready_out = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    ready_out = !(valid_in && sop_in && w_hit && full[w_idx]);
                    if (valid_in && ready_out) begin
                        if (sop_in && w_hit) begin
                            wr_en       = ONE_HOT0 << w_idx;
                            wr_last     = eop_in;
                            w_dest_nxt  = w_idx;
                            w_cnt_nxt   = CNT_W'(1'b1);
                            w_state_nxt = eop_in ? IDLE : FWD;
                        end else if (sop_in) begin
                            w_drop_nxt  = 1'b1;
                            w_state_nxt = eop_in ? IDLE : DROP;
                        end else begin
                            w_perr_nxt  = 1'b1;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                FWD: begin
                    ready_out = !full[r_dest];
                    if (valid_in && ready_out) begin
                        wr_en      = ONE_HOT0 << r_dest;
                        wr_last    = eop_in || (r_beat_cnt == LAST_CNT);
                        w_cnt_nxt  = r_beat_cnt + CNT_W'(1'b1);
                        w_perr_nxt = sop_in;
                        // eop on the limiting beat terminates normally, no truncation.
                        if (eop_in) begin
                            w_state_nxt = IDLE;
                        end else if (r_beat_cnt == LAST_CNT) begin
                            w_trunc_nxt = 1'b1;
                            w_state_nxt = DROP;
                        end else begin
                            w_state_nxt = FWD;
                        end
                    end else begin
                        w_state_nxt = FWD;
                    end
                end
                DROP: begin
                    ready_out = 1'b1;
                    if (valid_in) begin
                        w_perr_nxt  = sop_in;
                        w_state_nxt = eop_in ? IDLE : DROP;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, destination, beat counter and event pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dest     <= '0;
            r_beat_cnt <= '0;
            r_drop     <= 1'b0;
            r_trunc    <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dest     <= w_dest_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_drop     <= w_drop_nxt;
            r_trunc    <= w_trunc_nxt;
            r_perr     <= w_perr_nxt;
        end
    end

endmodule
